// File: rtl/regfile_bank_if.sv
// Command/observation bundle for regfile_bank: write port, pointer port, bulk clear,
// and the flattened register bus that feeds the address-select mux.
interface regfile_bank_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 32,
    parameter int AW    = 5
);
    // No valid/ready pair: commands are sampled on every rising edge while busy is low,
    // and are silently ignored while busy is high (busy is the only back-pressure).
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [WIDTH-1:0]      wdata;
    logic [1:0]            ptr_op;
    logic [AW-1:0]         ptr_sel;
    logic                  clr;
    logic [NREG*WIDTH-1:0] regfile;
    logic                  busy;
    logic                  ptr_wrap;
    logic                  fsm_state;

    modport master (
        output we, waddr, wdata, ptr_op, ptr_sel, clr,
        input  regfile, busy, ptr_wrap, fsm_state
    );

    modport slave (
        input  we, waddr, wdata, ptr_op, ptr_sel, clr,
        output regfile, busy, ptr_wrap, fsm_state
    );
endinterface

// File: rtl/regfile_bank.sv
// Byte-wide register bank with a write port, pointer inc/dec port and a sequenced
// bulk clear; all registers are exposed continuously on a flattened bus.
module regfile_bank #(
    parameter int WIDTH = 8,
    parameter int NREG  = 32,
    parameter int AW    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_bank_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] regs [NREG];
    logic             busy_q;
    logic             wrap_q;
    logic             ptr_blocked;

    // A write to the pointer's own index takes priority and suppresses the pointer op.
    assign ptr_blocked = bus.we && (bus.waddr == bus.ptr_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    wrap_q <= 1'b0;
                    if (bus.clr) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        if (!ptr_blocked && bus.ptr_op == 2'b01) begin
                            regs[bus.ptr_sel] <= regs[bus.ptr_sel] + WIDTH'(1);
                            wrap_q            <= (regs[bus.ptr_sel] == '1);
                        end else if (!ptr_blocked && bus.ptr_op == 2'b10) begin
                            regs[bus.ptr_sel] <= regs[bus.ptr_sel] - WIDTH'(1);
                            wrap_q            <= (regs[bus.ptr_sel] == '0);
                        end
                        if (bus.we) begin
                            regs[bus.waddr] <= bus.wdata;
                        end
                    end
                end
                CLEAR: begin
                    wrap_q     <= 1'b0;
                    regs[cnt]  <= '0;
                    cnt        <= cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    wrap_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.regfile = '0;
        for (int n = 0; n < NREG; n++) begin
            bus.regfile[n*WIDTH +: WIDTH] = regs[n];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ptr_wrap  = wrap_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: a per-cycle compare against an array model of the
// bank plus literal expectations for the documented scenarios.
module tb_regfile_bank;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_bank_if #(.WIDTH(8), .NREG(32), .AW(5)) bus ();

    regfile_bank #(.WIDTH(8), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [32];
    int         sweep_left;
    logic       m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            sweep_left = 0;
            m_wrap     = 1'b0;
        end else if (sweep_left > 0) begin
            m_regs[32 - sweep_left] = 8'h00;
            sweep_left = sweep_left - 1;
            m_wrap     = 1'b0;
        end else if (bus.clr) begin
            sweep_left = 32;
            m_wrap     = 1'b0;
        end else begin
            int v;
            v      = int'(m_regs[bus.ptr_sel]);
            m_wrap = 1'b0;
            if (!(bus.we && bus.waddr == bus.ptr_sel)) begin
                if (bus.ptr_op == 2'b01) begin
                    m_wrap = (v == 255);
                    m_regs[bus.ptr_sel] = 8'((v + 1) % 256);
                end else if (bus.ptr_op == 2'b10) begin
                    m_wrap = (v == 0);
                    m_regs[bus.ptr_sel] = 8'((v + 255) % 256);
                end
            end
            if (bus.we) m_regs[bus.waddr] = bus.wdata;
        end
    end

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int n = 0; n < 32; n++) f[n*8 +: 8] = m_regs[n];
        return f;
    endfunction

    function automatic logic [7:0] dut_reg(input int n);
        logic [255:0] rf;
        rf = bus.regfile;
        return rf[n*8 +: 8];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_regfile", bus.regfile, model_flat());
            check("cyc_busy", 256'(bus.busy), 256'(sweep_left > 0));
            check("cyc_fsm_state", 256'(bus.fsm_state), 256'(sweep_left > 0));
            check("cyc_ptr_wrap", 256'(bus.ptr_wrap), 256'(m_wrap));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.ptr_op = 2'b00; bus.ptr_sel = '0; bus.clr = 1'b0;
    endtask

    task automatic write(input int a, input logic [7:0] d);
        bus.we = 1'b1; bus.waddr = 5'(a); bus.wdata = d;
        step();
        bus.we = 1'b0;
    endtask

    task automatic ptr(input logic [1:0] op, input int sel);
        bus.ptr_op = op; bus.ptr_sel = 5'(sel);
        step();
        bus.ptr_op = 2'b00;
    endtask

    // Counts busy cycles of a sweep already started; optional write mid-sweep.
    task automatic count_busy(input int stop_at, output int n);
        int guard;
        n = 0;
        guard = 0;
        while (bus.busy && guard < 40 && (stop_at == 0 || n < stop_at)) begin
            n++;
            bus.we = (n == 5); bus.waddr = 5'd0; bus.wdata = 8'hFF;
            step();
            guard++;
        end
        bus.we = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [255:0] exp_v;
        int           n;
        checks = 0;
        errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_regfile", bus.regfile, 256'h0);
        check("reset_busy", 256'(bus.busy), 256'h0);
        check("reset_wrap", 256'(bus.ptr_wrap), 256'h0);
        rst_n = 1'b1;

        // single write
        write(5, 8'hA7);
        exp_v = 256'hA7 << 40;
        check("write_reg5", 256'(dut_reg(5)), 256'hA7);
        check("write_only_reg5", bus.regfile, exp_v);

        // pointer wrap both directions
        write(3, 8'hFF);
        ptr(2'b01, 3);
        check("inc_wrap_val", 256'(dut_reg(3)), 256'h00);
        check("inc_wrap_flag", 256'(bus.ptr_wrap), 256'h1);
        step();
        check("wrap_one_cycle", 256'(bus.ptr_wrap), 256'h0);
        ptr(2'b10, 3);
        check("dec_wrap_val", 256'(dut_reg(3)), 256'hFF);
        check("dec_wrap_flag", 256'(bus.ptr_wrap), 256'h1);

        // write vs pointer on same / different index
        bus.ptr_op = 2'b01; bus.ptr_sel = 5'd7;
        write(7, 8'h10);
        bus.ptr_op = 2'b00;
        check("same_idx_val", 256'(dut_reg(7)), 256'h10);
        check("same_idx_wrap", 256'(bus.ptr_wrap), 256'h0);
        write(8, 8'h41);
        bus.ptr_op = 2'b01; bus.ptr_sel = 5'd8;
        write(7, 8'h10);
        bus.ptr_op = 2'b00;
        check("diff_idx_reg7", 256'(dut_reg(7)), 256'h10);
        check("diff_idx_reg8", 256'(dut_reg(8)), 256'h42);

        // back-to-back mixed ops, checked by the model every cycle
        write(10, 8'h80);
        ptr(2'b01, 10);
        ptr(2'b10, 10);
        ptr(2'b10, 10);
        ptr(2'b11, 10);
        write(11, 8'h00);
        ptr(2'b10, 11);
        check("b2b_reg10", 256'(dut_reg(10)), 256'h7F);
        check("b2b_reg11", 256'(dut_reg(11)), 256'hFF);

        // fill + full sweep with a write mid-sweep
        for (int i = 0; i < 32; i++) write(i, 8'h5A);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        count_busy(0, n);
        check("sweep_busy_cycles", 256'(n), 256'd32);
        check("sweep_all_zero", bus.regfile, 256'h0);
        check("sweep_busy_low", 256'(bus.busy), 256'h0);

        // reset in the middle of a sweep
        write(20, 8'h77);
        write(31, 8'h12);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        count_busy(10, n);
        check("mid_sweep_reg20", 256'(dut_reg(20)), 256'h77);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_regfile", bus.regfile, 256'h0);
        check("async_rst_busy", 256'(bus.busy), 256'h0);
        check("async_rst_wrap", 256'(bus.ptr_wrap), 256'h0);
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 8'h33;
        rst_n = 1'b1;
        step();
        bus.we = 1'b0;
        check("first_edge_write", 256'(dut_reg(31)), 256'h33);

        // clr and we in the same idle cycle
        bus.clr = 1'b1; bus.we = 1'b1; bus.waddr = 5'd2; bus.wdata = 8'h99;
        step();
        idle_inputs();
        check("clr_we_reg2", 256'(dut_reg(2)), 256'h00);
        count_busy(0, n);
        check("clr_we_busy_cycles", 256'(n), 256'd32);
        check("clr_we_all_zero", bus.regfile, 256'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_bank.md
# regfile_bank

General-purpose register bank of NREG byte-wide registers that produces the flattened `regfile` bus consumed by the address-select mux. It provides one synchronous write port, a pointer increment/decrement port for address registers, and a sequenced bulk-clear operation. All register state is exposed continuously on the flattened bus so the downstream mux can select any register combinationally.

## Interface
- `WIDTH`, 8, bits per register; fixed at 8 for the address mux.
- `NREG`, 32, number of registers; fixed at 32 for the address mux.
- `AW`, 5, register index width, log2(NREG).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable.
- `waddr`  in  AW  write register index.
- `wdata`  in  WIDTH  write data.
- `ptr_op`  in  2  pointer operation: 00 none, 01 increment, 10 decrement, 11 none.
- `ptr_sel`  in  AW  register index targeted by `ptr_op`.
- `clr`  in  1  bulk-clear request, sampled only in IDLE.
- `regfile`  out  NREG*WIDTH  flattened registers; register n occupies bits [8n+7:8n].
- `busy`  out  1  high while a clear sweep is in progress.
- `ptr_wrap`  out  1  one-cycle pulse when a pointer operation wraps.

## Operation
- The state machine has two states: IDLE and CLEAR. A 5-bit sweep counter `cnt` is internal.
- IDLE, `clr`=1: go to CLEAR with `cnt`=0. `we` and `ptr_op` in that cycle are ignored.
- IDLE, `clr`=0, `we`=1: reg[waddr] <= wdata.
- IDLE, `clr`=0, `ptr_op`=01: reg[ptr_sel] <= reg[ptr_sel]+1, modulo 256.
- IDLE, `clr`=0, `ptr_op`=10: reg[ptr_sel] <= reg[ptr_sel]-1, modulo 256.
- Write and pointer operation on different indices: both are performed in the same cycle.
- Write and pointer operation on the same index: the write wins, the pointer operation is dropped, and `ptr_wrap` stays 0.
- `ptr_wrap` is registered. It is 1 for the cycle after an executed increment from 0xFF or decrement from 0x00; otherwise it is 0.
- CLEAR: each cycle, reg[cnt] <= 0 and `cnt` increments. After clearing reg[31], return to IDLE.
- In CLEAR, `we`, `ptr_op` and `clr` are ignored and `ptr_wrap` is 0.
- `busy` = (state == CLEAR), driven from a register.
- `regfile` is a direct concatenation of the register outputs, with no combinational path from the inputs.
- Reset (`rst_n`=0, at any time, including mid-sweep): all registers 0x00, `regfile` all zeros, `busy` 0, `ptr_wrap` 0, state IDLE, `cnt` 0. The effect is immediate, independent of `clk`.

## Timing
- Write latency: 1 cycle. Data presented at edge k appears on `regfile` right after edge k. No bypass: a same-cycle read through the mux returns the old value.
- Pointer latency: 1 cycle, identical to a write. `ptr_wrap` is asserted during the cycle after the wrapping edge.
- Clear: `clr` sampled at edge k sets `busy` high after edge k. Registers 0..31 are cleared at edges k+1..k+32. `busy` falls after edge k+32, so `busy` is high for exactly 32 cycles.
- New commands are accepted from edge k+33 onward.
- Back-to-back writes and pointer operations are sustained at one per cycle in IDLE.
- Reset release: the first accepted operation is at the first rising edge with `rst_n`=1.

## Test plan
- Reset, then `we`=1, `waddr`=5, `wdata`=0xA7 for one cycle -> next cycle `regfile`[47:40]=0xA7; all other bits 0.
- Load reg3=0xFF, then `ptr_op`=01, `ptr_sel`=3 -> reg3=0x00 and `ptr_wrap`=1 for one cycle. Then `ptr_op`=10 -> reg3=0xFF and `ptr_wrap` pulses again.
- Same cycle: `we`=1, `waddr`=7, `wdata`=0x10 and `ptr_op`=01, `ptr_sel`=7 -> reg7=0x10, `ptr_wrap`=0. Repeat with `ptr_sel`=8 holding 0x41 -> reg7=0x10, reg8=0x42.
- Fill all 32 registers with 0x5A, pulse `clr` -> `busy` high for exactly 32 cycles, reg n reads 0 after the (n+1)th sweep cycle. `we` issued mid-sweep has no effect; `regfile`=0 when `busy` falls.
- Start a clear, assert `rst_n`=0 at sweep cycle 10 -> all outputs 0 immediately. After release, a write to reg31 of 0x33 succeeds on the first edge.
- Assert `clr` and `we` (`waddr`=2, `wdata`=0x99) in the same IDLE cycle -> the write is dropped, reg2=0x00 throughout, and the sweep runs normally.
